seq_mult_16: RTL and testbench

SEQ_MULT_16 -- requirements
Module: seq_mult_16

---
 rtl/seq_mult_16_pkg.sv | 17 +
 rtl/seq_mult_16_cla.sv | 56 +++++
 rtl/seq_mult_16.sv | 119 +++++++++++
 tb/tb_seq_mult_16.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seq_mult_16_pkg.sv
// Shared definitions for the sequential 16x16 shift-add multiplier.
//   state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   WIDTH_DEF : operand width of the datapath
//   CNT_LAST  : iteration count value on the final RUN cycle
package seq_mult_16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(WIDTH_DEF - 1);

endpackage

// File: rtl/seq_mult_16_cla.sv
// CLA_16bit: 16-bit two-level carry-lookahead adder.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low 16 bits
//   cout : carry out of bit 15
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, pp;
  logic [4:0]  bc;

  always_comb begin
    g = a & b;
    p = a ^ b;

    // group generate/propagate per nibble
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pp[k] = &p[4*k +: 4];
    end

    // second-level lookahead across nibbles
    bc[0] = cin;
    bc[1] = gg[0] | (pp[0] & cin);
    bc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
    bc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
          | (pp[2] & pp[1] & pp[0] & cin);
    bc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
          | (pp[3] & pp[2] & pp[1] & gg[0])
          | (pp[3] & pp[2] & pp[1] & pp[0] & cin);

    // in-nibble carries from the nibble carry-in
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = bc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & bc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
    end

    sum  = p ^ c;
    cout = bc[4];
  end

endmodule

// File: rtl/seq_mult_16.sv
// seq_mult_16: sequential unsigned shift-add multiplier, one partial
// product per cycle through a CLA_16bit adder.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operands present on a/b
//   in_ready  : accepting operands (IDLE only)
//   a, b      : unsigned multiplicand / multiplier
//   out_valid : product valid (DONE only)
//   out_ready : consumer accepts the product
//   product   : registered a*b
//   busy      : high while iterating (RUN)
//
// Latency: handshake at edge N, 16 RUN cycles, DONE entered at N+16 with
// the result registered, out_valid raised at N+17.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one add/shift iteration per cycle
// DONE  | result held, out_valid after one settle cycle
import seq_mult_16_pkg::*;

module seq_mult_16 #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   m_q, h_q, q_q;
  logic [4:0]         count;
  logic [2*WIDTH-1:0] product_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   addend, sum, h_nxt, q_nxt;
  logic               cout;
  logic               last_iter;

  assign addend    = q_q[0] ? m_q : '0;
  assign last_iter = (count == CNT_LAST);

  CLA_16bit u_cla (
    .a    (h_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout, sum, Q} >> 1: the carry lands in H's msb, nothing is lost
  assign h_nxt = {cout, sum[WIDTH-1:1]};
  assign q_nxt = {sum[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last_iter) state_nxt = ST_DONE;
      ST_DONE: if (out_valid_q && out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_RUN);
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q         <= '0;
      h_q         <= '0;
      q_q         <= '0;
      count       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            m_q   <= a;
            q_q   <= b;
            h_q   <= '0;
            count <= '0;
          end
        end
        ST_RUN: begin
          h_q   <= h_nxt;
          q_q   <= q_nxt;
          count <= count + 5'd1;
          if (last_iter) product_q <= {h_nxt, q_nxt};
        end
        ST_DONE: begin
          // first DONE cycle raises out_valid; handshake drops it
          out_valid_q <= !(out_valid_q && out_ready);
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_16.sv
module tb_seq_mult_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int op_id    = 0;

  always #5 clk = ~clk;

  seq_mult_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL op%0d %s observed=%0h expected=%0h", op_id, tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input int stall, input logic [31:0] exp, input bit intrude);
    int n;
    int busy_n;
    logic [31:0] held;
    op_id++;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n      = 0;
    busy_n = 0;
    while (!out_valid && n < 40) begin
      if (busy) busy_n++;
      if (n == 2) chk("in_ready_run", 64'(in_ready), 64'd0);
      if (intrude && n == 3) begin
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd17);
    chk("busy_cycles", 64'(busy_n), 64'd16);
    held = product;
    for (int s = 0; s < stall; s++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_product", 64'(product), 64'(held));
      chk("in_ready_done", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("product", 64'(product), 64'(exp));
    chk("out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'd3,      16'd5,      0, 32'h0000_000F, 1'b0);
    run_op(16'hFFFF,   16'hFFFF,   1, 32'hFFFE_0001, 1'b0);
    run_op(16'h1234,   16'h0000,   0, 32'h0000_0000, 1'b0);
    run_op(16'h00FF,   16'h0100,   5, 32'h0000_FF00, 1'b1);

    // abort mid-RUN: product from previous op is nonzero, must clear
    op_id++;
    a        = 16'd7;
    b        = 16'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd7, 16'd9, 0, 32'd63, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) ra = 16'hFFFF;
      if (i == 1) rb = 16'h0001;
      run_op(ra, rb, int'($urandom_range(0, 3)), {16'h0, ra} * {16'h0, rb}, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
